sense_change_logger: RTL and testbench

//   Downstream consumer of the always-block sense outputs (out1..outB bundle).

---
 rtl/sense_change_logger.sv | 89 ++++++++
 tb/tb_sense_change_logger.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/sense_change_logger.sv
// Sense-vector change logger: samples a WIDTH-bit vector, records each change
// as {mask, value, timestamp} in a show-ahead FIFO drained by valid/ready.
module sense_change_logger #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 4,
   parameter int TS_W  = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       sample_en,
   input  logic [WIDTH-1:0]           sense_in,
   output logic                       ev_valid,
   input  logic                       ev_ready,
   output logic [WIDTH-1:0]           ev_mask,
   output logic [WIDTH-1:0]           ev_value,
   output logic [TS_W-1:0]            ev_time,
   output logic [$clog2(DEPTH):0]     ev_count,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [TS_W-1:0]  ts;
   logic [WIDTH-1:0] prev;
   logic             primed;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic [WIDTH-1:0] mask_mem  [DEPTH];
   logic [WIDTH-1:0] value_mem [DEPTH];
   logic [TS_W-1:0]  time_mem  [DEPTH];

   logic push, pop, full, accept, drop;

   assign push   = primed & sample_en & (sense_in != prev);
   assign pop    = (count != '0) & ev_ready;
   assign full   = (count == CW'(DEPTH));
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign accept = push & (~full | pop);
   assign drop   = push & full & ~pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts       <= '0;
         prev     <= '0;
         primed   <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         ts <= ts + TS_W'(1);
         if (sample_en) begin
            prev   <= sense_in;
            primed <= 1'b1;
         end
         if (accept) wr_ptr <= wr_ptr + AW'(1);
         if (pop)    rd_ptr <= rd_ptr + AW'(1);
         case ({accept, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
         end
      end
   end

   // Storage carries no reset; empty-state outputs are forced to zero below.
   always_ff @(posedge clk) begin
      if (accept) begin
         mask_mem[wr_ptr]  <= sense_in ^ prev;
         value_mem[wr_ptr] <= sense_in;
         time_mem[wr_ptr]  <= ts;
      end
   end

   assign ev_valid = (count != '0);
   assign ev_count = count;
   assign ev_mask  = ev_valid ? mask_mem[rd_ptr]  : '0;
   assign ev_value = ev_valid ? value_mem[rd_ptr] : '0;
   assign ev_time  = ev_valid ? time_mem[rd_ptr]  : '0;

endmodule

// File: tb/tb_sense_change_logger.sv
// Scoreboard bench for sense_change_logger: directed samples push expected
// events; a negedge monitor compares every popped head against the queue.
module tb_sense_change_logger;
   logic        clk = 1'b0;
   logic        rst;
   logic        sample_en;
   logic [10:0] sense_in;
   logic        ev_valid;
   logic        ev_ready;
   logic [10:0] ev_mask;
   logic [10:0] ev_value;
   logic [7:0]  ev_time;
   logic [2:0]  ev_count;
   logic        overflow;
   logic [7:0]  drop_cnt;

   int errors = 0;
   int checks = 0;
   logic [7:0]  cyc;
   logic [29:0] exp_q [$];

   always #5 clk = ~clk;

   sense_change_logger #(.WIDTH(11), .DEPTH(4), .TS_W(8)) dut (
      .clk(clk), .rst(rst), .sample_en(sample_en), .sense_in(sense_in),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mask(ev_mask),
      .ev_value(ev_value), .ev_time(ev_time), .ev_count(ev_count),
      .overflow(overflow), .drop_cnt(drop_cnt)
   );

   // Cycles since reset release; equals the timestamp the next sampling edge captures.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 8'd0;
      else     cyc <= cyc + 8'd1;
   end

   always @(negedge clk) begin
      if (!rst && ev_valid && ev_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got mask=%h value=%h time=%h, required none",
                     ev_mask, ev_value, ev_time);
         end else begin
            logic [29:0] e;
            e = exp_q.pop_front();
            if ({ev_mask, ev_value, ev_time} !== e) begin
               errors++;
               $display("FAIL ev_pop: got mask=%h value=%h time=%h, required mask=%h value=%h time=%h",
                        ev_mask, ev_value, ev_time, e[29:19], e[18:8], e[7:0]);
            end else begin
               $display("event: mask=%h value=%h time=%h ok", ev_mask, ev_value, ev_time);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [10:0] v, input bit push,
                         input logic [10:0] mask, input logic [7:0] t);
      sense_in  = v;
      sample_en = 1'b1;
      if (push) exp_q.push_back({mask, v, t});
      step();
      sample_en = 1'b0;
   endtask

   task automatic drain(input string name);
      ev_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (ev_count == 3'd0 && exp_q.size() == 0) break;
         step();
      end
      ev_ready = 1'b0;
      chk({name, "_count"}, int'(ev_count), 0);
      chk({name, "_pending"}, exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1; sample_en = 1'b0; sense_in = '0; ev_ready = 1'b0;
      repeat (3) step();
      chk("reset_valid", int'(ev_valid), 0);
      chk("reset_count", int'(ev_count), 0);
      chk("reset_overflow", int'(overflow), 0);
      chk("reset_drop_cnt", int'(drop_cnt), 0);
      chk("reset_head", int'({ev_mask, ev_value, ev_time}), 0);
      rst = 1'b0;
      step();

      // 1: first sample silent, change gives one event visible next cycle
      sample(11'h000, 0, 11'h000, cyc);
      chk("t1_first_no_event", int'(ev_valid), 0);
      sample(11'h005, 1, 11'h005, cyc);
      chk("t1_valid_next_cycle", int'(ev_valid), 1);
      chk("t1_count", int'(ev_count), 1);
      drain("t1_drain");

      // 2: repeated value, no event
      sample(11'h005, 0, 11'h000, cyc);
      sample(11'h005, 0, 11'h000, cyc);
      step();
      chk("t2_count", int'(ev_count), 0);

      // 3: six changes into a 4-deep FIFO with consumer stalled
      sample(11'h001, 1, 11'h004, cyc);
      sample(11'h003, 1, 11'h002, cyc);
      sample(11'h007, 1, 11'h004, cyc);
      sample(11'h00F, 1, 11'h008, cyc);
      sample(11'h01F, 0, 11'h000, cyc);
      sample(11'h03F, 0, 11'h000, cyc);
      chk("t3_count", int'(ev_count), 4);
      chk("t3_overflow", int'(overflow), 1);
      chk("t3_drop_cnt", int'(drop_cnt), 2);

      // 4: full FIFO, push and pop together; mask relative to dropped sample
      ev_ready = 1'b1;
      sample(11'h07F, 1, 11'h040, cyc);
      ev_ready = 1'b0;
      chk("t4_count", int'(ev_count), 4);
      chk("t4_drop_cnt", int'(drop_cnt), 2);
      drain("t4_drain");

      // 5: saturate drop counter, then catch the timestamp wrap
      sample(11'h0FF, 1, 11'h080, cyc);
      sample(11'h1FF, 1, 11'h100, cyc);
      sample(11'h3FF, 1, 11'h200, cyc);
      sample(11'h3FE, 1, 11'h001, cyc);
      for (int i = 0; i < 260; i++)
         sample((i % 2 == 0) ? 11'h000 : 11'h3FE, 0, 11'h000, cyc);
      chk("t5_count_full", int'(ev_count), 4);
      chk("t5_drop_sat", int'(drop_cnt), 255);
      drain("t5_drain");
      for (int i = 0; i < 300; i++) begin
         if (cyc == 8'hFF) break;
         step();
      end
      chk("t5_wait_ts_ff", int'(cyc), 255);
      sample(11'h3FF, 1, 11'h001, 8'hFF);
      sample(11'h000, 1, 11'h3FF, 8'h00);
      drain("t5_wrap_drain");
      chk("t5_drop_still_sat", int'(drop_cnt), 255);

      // 6: reset with three events queued
      sample(11'h001, 1, 11'h001, cyc);
      sample(11'h002, 1, 11'h003, cyc);
      sample(11'h004, 1, 11'h006, cyc);
      chk("t6_count_before", int'(ev_count), 3);
      rst = 1'b1;
      #1;
      chk("t6_valid_in_reset", int'(ev_valid), 0);
      chk("t6_count_in_reset", int'(ev_count), 0);
      chk("t6_head_in_reset", int'({ev_mask, ev_value, ev_time}), 0);
      exp_q.delete();
      step();
      rst = 1'b0;
      chk("t6_overflow_cleared", int'(overflow), 0);
      chk("t6_drop_cleared", int'(drop_cnt), 0);
      sample(11'h123, 0, 11'h000, cyc);
      step();
      chk("t6_first_no_event", int'(ev_count), 0);
      sample(11'h124, 1, 11'h007, cyc);
      chk("t6_valid_after", int'(ev_valid), 1);
      drain("t6_drain");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
